alu_issue_ctrl: RTL and testbench

Execute-stage sequencer in front of the ALU. Takes one decoded op per valid/ready handshake, holds the operands steady on the ALU inputs, and counts the latency of the op's class (simple, multiply or divide). It then captures the ALU's 128-bit result and 64-bit flags into an output register and hands them to the memory stage through a valid/ready handshake. It also handles pipeline flush, divide-by-zero and illegal op classes.

---
 rtl/alu_issue_ctrl_if.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle for alu_issue_ctrl: decode-side op, ALU drive/return, memory-stage result.
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
    parameter int OPC_W = 10,
    parameter int DST_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OPC_W-1:0] in_opcode;
    logic [1:0]       in_class;
    logic [63:0]      in_oprd1;
    logic [63:0]      in_oprd2;
    logic [63:0]      in_oprd3;
    logic [DST_W-1:0] in_dst;
    logic             alu_enable;
    logic [OPC_W-1:0] alu_opcode;
    logic [63:0]      alu_oprd1;
    logic [63:0]      alu_oprd2;
    logic [63:0]      alu_oprd3;
    logic [127:0]     alu_result;
    logic [63:0]      alu_flags;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_result;
    logic [63:0]      out_flags;
    logic [DST_W-1:0] out_dst;
    logic             out_err;
    logic             busy;

    modport slave (
        input  flush, in_valid, in_opcode, in_class,
        input  in_oprd1, in_oprd2, in_oprd3, in_dst,
        input  alu_result, alu_flags, out_ready,
        output in_ready, alu_enable, alu_opcode,
        output alu_oprd1, alu_oprd2, alu_oprd3,
        output out_valid, out_result, out_flags,
        output out_dst, out_err, busy
    );

    modport master (
        output flush, in_valid, in_opcode, in_class,
        output in_oprd1, in_oprd2, in_oprd3, in_dst,
        output alu_result, alu_flags, out_ready,
        input  in_ready, alu_enable, alu_opcode,
        input  alu_oprd1, alu_oprd2, alu_oprd3,
        input  out_valid, out_result, out_flags,
        input  out_dst, out_err, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU sequencer: hold operands, count class latency, register result.
// Optional perf counters perf_ops/perf_stall enabled by ALU_CTRL_PERF_EN.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int OPC_W   = 10,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    parameter int DST_W   = 4
) (
    input  logic clk,
    input  logic reset,
    alu_issue_ctrl_if.slave bus
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, nxt;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    lat;
    logic [OPC_W-1:0] op_q;
    logic [63:0]      a_q, b_q, c_q;
    logic [DST_W-1:0] dst_q;
    logic [127:0]     res_q;
    logic [63:0]      flg_q;
    logic [DST_W-1:0] odst_q;
    logic             err_q;
    logic             ready;
    logic             accept;
    logic             bad_op;

    assign ready = !bus.flush &&
        (state == IDLE || (state == DONE && bus.out_ready));
    assign accept = bus.in_valid && ready;

    // Illegal class or divide-by-zero never reaches the ALU.
    assign bad_op = (bus.in_class == 2'd3) ||
        (bus.in_class == 2'd2 && bus.in_oprd2 == 64'd0);

    always_comb begin
        lat = CW'(1);
        case (bus.in_class)
            2'd1:    lat = CW'(MUL_LAT);
            2'd2:    lat = CW'(DIV_LAT);
            default: lat = CW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (bus.flush) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) nxt = bad_op ? DONE : EXEC;
                end
                EXEC: begin
                    if (cnt == CW'(1)) nxt = DONE;
                end
                DONE: begin
                    if (accept)             nxt = bad_op ? DONE : EXEC;
                    else if (bus.out_ready) nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            dst_q  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
            odst_q <= '0;
            err_q  <= 1'b0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q  <= bus.in_opcode;
            a_q   <= bus.in_oprd1;
            b_q   <= bus.in_oprd2;
            c_q   <= bus.in_oprd3;
            dst_q <= bus.in_dst;
            if (bad_op) begin
                cnt    <= '0;
                res_q  <= '0;
                flg_q  <= '0;
                odst_q <= bus.in_dst;
                err_q  <= 1'b1;
            end else begin
                cnt <= lat;
            end
        end else if (state == EXEC) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                res_q  <= bus.alu_result;
                flg_q  <= bus.alu_flags;
                odst_q <= dst_q;
                err_q  <= 1'b0;
            end
        end
    end

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else if (state == DONE) begin
            if (bus.out_ready) perf_ops   <= perf_ops + 32'd1;
            else               perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    assign bus.in_ready   = ready;
    assign bus.alu_enable = (state == EXEC);
    assign bus.alu_opcode = op_q;
    assign bus.alu_oprd1  = a_q;
    assign bus.alu_oprd2  = b_q;
    assign bus.alu_oprd3  = c_q;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = res_q;
    assign bus.out_flags  = flg_q;
    assign bus.out_dst    = odst_q;
    assign bus.out_err    = err_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.OPC_W(10), .DST_W(4)) bus ();

`ifdef ALU_CTRL_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    alu_issue_ctrl #(
        .OPC_W(10), .MUL_LAT(3), .DIV_LAT(16), .DST_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_ops(perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    // ALU model: opcode 2 = mul, 3 = div, else add; flags echo opcode.
    always_comb begin
        case (bus.alu_opcode)
            10'd2: bus.alu_result = {64'd0, bus.alu_oprd1} * {64'd0, bus.alu_oprd2};
            10'd3: bus.alu_result = (bus.alu_oprd2 == 64'd0) ? 128'd0 :
                                    {64'd0, bus.alu_oprd1 / bus.alu_oprd2};
            default: bus.alu_result = {64'd0, bus.alu_oprd1 + bus.alu_oprd2};
        endcase
        bus.alu_flags = {54'd0, bus.alu_opcode};
    end

    typedef struct {
        logic [1:0]   cls;
        logic [9:0]   op;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [3:0]   dst;
        logic [127:0] res;
        logic [63:0]  flg;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] cls, input logic [9:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] dst);
        bus.in_class  = cls;
        bus.in_opcode = op;
        bus.in_oprd1  = a;
        bus.in_oprd2  = b;
        bus.in_oprd3  = a ^ 64'h5a5a;
        bus.in_dst    = dst;
        bus.in_valid  = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int k;
        int en;
        string s;
        s = $sformatf("v%0d", n);
        @(negedge clk);
        drive(v.cls, v.op, v.a, v.b, v.dst);
        bus.out_ready = 1'b1;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({s, "_accept"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        en = 0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            if (bus.alu_enable) en++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({s, "_lat"}, k, v.lat);
        chk({s, "_en_cycles"}, en, v.err ? 0 : v.lat);
        chk({s, "_result"}, bus.out_result, v.res);
        chk({s, "_flags"}, bus.out_flags, v.flg);
        chk({s, "_err"}, bus.out_err, v.err);
        if (!v.err) chk({s, "_dst"}, bus.out_dst, v.dst);
        @(posedge clk);
        #1;
        chk({s, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int k, en, idx, got, last;
        logic acc;
        logic [127:0] bb_res[4];

        vecs[0] = '{2'd0, 10'd1, 64'd5, 64'd7, 4'd1, 128'd12, 64'd1, 1'b0, 1};
        vecs[1] = '{2'd1, 10'd2, 64'd3, 64'd4, 4'd2, 128'd12, 64'd2, 1'b0, 3};
        vecs[2] = '{2'd2, 10'd3, 64'd100, 64'd7, 4'd3, 128'd14, 64'd3, 1'b0, 16};
        vecs[3] = '{2'd2, 10'd3, 64'd100, 64'd0, 4'd4, 128'd0, 64'd0, 1'b1, 0};
        vecs[4] = '{2'd3, 10'd1, 64'd5, 64'd7, 4'd5, 128'd0, 64'd0, 1'b1, 0};
        vecs[5] = '{2'd1, 10'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd6,
                    128'h1_FFFF_FFFF_FFFF_FFFE, 64'd2, 1'b0, 3};
        vecs[6] = '{2'd0, 10'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd15,
                    128'd0, 64'd1, 1'b0, 1};
        vecs[7] = '{2'd2, 10'd3, 64'd0, 64'd5, 4'd8, 128'd0, 64'd3, 1'b0, 16};
        bb_res[0] = 128'd3;
        bb_res[1] = 128'd14;
        bb_res[2] = 128'd25;
        bb_res[3] = 128'd36;

        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'd0, 10'd0, 64'd0, 64'd0, 4'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_alu_enable", bus.alu_enable, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Multiply held under backpressure
        @(negedge clk);
        drive(2'd1, 10'd2, 64'd6, 64'd7, 4'd9);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        en = 0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            if (bus.alu_enable) en++;
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp_lat", k, 3);
        chk("bp_en", en, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_hold%0d", i), bus.out_result, 42);
            chk($sformatf("bp_ready%0d", i), bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release", bus.in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_idle", bus.busy, 0);

        // Flush during divide EXEC cycle 5
        @(negedge clk);
        drive(2'd2, 10'd3, 64'd100, 64'd7, 4'd3);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("fl_exec", bus.alu_enable, 1);
        @(negedge clk);
        bus.flush = 1'b1;
        drive(2'd0, 10'd1, 64'd20, 64'd22, 4'd7);
        #1;
        chk("fl_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("fl_idle", bus.busy, 0);
        chk("fl_no_valid", bus.out_valid, 0);
        chk("fl_no_enable", bus.alu_enable, 0);
        @(negedge clk);
        chk("fl_new_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("fl_new_lat", k, 1);
        chk("fl_new_result", bus.out_result, 42);
        chk("fl_new_dst", bus.out_dst, 7);
        @(posedge clk);
        #1;

        // Back-to-back simple ops, tags 1..4
        idx = 0;
        got = 0;
        last = -1;
        @(negedge clk);
        drive(2'd0, 10'd1, 64'd1, 64'd2, 4'd1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.out_valid) begin
                if (got < 4) begin
                    chk($sformatf("bb_dst%0d", got), bus.out_dst, got + 1);
                    chk($sformatf("bb_res%0d", got), bus.out_result, bb_res[got]);
                end
                if (last >= 0) chk($sformatf("bb_gap%0d", got), c - last, 2);
                last = c;
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4)
                    drive(2'd0, 10'd1, 64'(idx * 10 + 1), 64'(idx + 2),
                          4'(idx + 1));
                else
                    bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("bb_count", got, 4);

        // Reset during multiply EXEC cycle 2
        @(negedge clk);
        drive(2'd1, 10'd2, 64'd5, 64'd5, 4'd11);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_exec", bus.alu_enable, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr_busy", bus.busy, 0);
        chk("mr_enable", bus.alu_enable, 0);
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_result", bus.out_result, 0);
        chk("mr_flags", bus.out_flags, 0);
        chk("mr_dst", bus.out_dst, 0);
        chk("mr_err", bus.out_err, 0);
        chk("mr_opcode", bus.alu_opcode, 0);
        chk("mr_oprd1", bus.alu_oprd1, 0);
        chk("mr_oprd3", bus.alu_oprd3, 0);
        chk("mr_in_ready", bus.in_ready, 1);
`ifdef ALU_CTRL_PERF_EN
        chk("mr_perf_ops", perf_ops, 0);
        chk("mr_perf_stall", perf_stall, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
